// File: rtl/adder_result_misr.sv
// Response compactor: folds the adder {cout, sum} stream into a MISR and checks
// the signature after SAMPLE_COUNT samples. Optional watchdog: MISR_TIMEOUT_EN.
module adder_result_misr #(
   parameter int                   DATA_WIDTH     = 500,
   parameter int                   SIG_WIDTH      = 32,
   parameter logic [SIG_WIDTH-1:0] POLY           = 32'h04C11DB7,
   parameter logic [SIG_WIDTH-1:0] SEED           = '1,
   parameter int                   SAMPLE_COUNT   = 1024,
   parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG     = '0,
   parameter int                   TIMEOUT_CYCLES = 4096
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              in_valid,
   input  logic [DATA_WIDTH-1:0]             data,
   input  logic                              cout,
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic                              timeout,
   output logic [SIG_WIDTH-1:0]              signature,
   output logic [$clog2(SAMPLE_COUNT+1)-1:0] sample_cnt
);

   localparam int VEC_W  = DATA_WIDTH + 1;
   localparam int NCHUNK = (VEC_W + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int PAD_W  = NCHUNK * SIG_WIDTH;
   localparam int CNT_W  = $clog2(SAMPLE_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_COUNT - 1);

   if (SAMPLE_COUNT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("adder_result_misr: SAMPLE_COUNT and TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   function automatic logic [SIG_WIDTH-1:0] fold(input logic [VEC_W-1:0] v);
      logic [PAD_W-1:0]     padded;
      logic [SIG_WIDTH-1:0] acc;
      padded = PAD_W'(v);
      acc    = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         acc = acc ^ padded[i*SIG_WIDTH +: SIG_WIDTH];
      end
      return acc;
   endfunction

   function automatic logic [SIG_WIDTH-1:0] misr_step(input logic [SIG_WIDTH-1:0] s,
                                                      input logic [SIG_WIDTH-1:0] f);
      return {s[SIG_WIDTH-2:0], 1'b0} ^ (s[SIG_WIDTH-1] ? POLY : '0) ^ f;
   endfunction

   state_t               state_q, state_nx;
   logic [SIG_WIDTH-1:0] sig_q, sig_nx, sig_step;
   logic [CNT_W-1:0]     cnt_q, cnt_nx;
   logic                 pass_q, pass_nx;
   logic                 busy_q, done_q;

`ifdef MISR_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_q, wd_nx;
   logic            tmo_q, tmo_nx;
`endif

   assign sig_step = misr_step(sig_q, fold({cout, data}));

   always_comb begin
      state_nx = state_q;
      sig_nx   = sig_q;
      cnt_nx   = cnt_q;
      pass_nx  = pass_q;
`ifdef MISR_TIMEOUT_EN
      wd_nx    = wd_q;
      tmo_nx   = tmo_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            // A start with a coincident in_valid only re-seeds; the sample is dropped.
            if (start) begin
               state_nx = S_COLLECT;
               sig_nx   = SEED;
               cnt_nx   = '0;
               pass_nx  = 1'b0;
`ifdef MISR_TIMEOUT_EN
               wd_nx    = '0;
               tmo_nx   = 1'b0;
`endif
            end
         end
         S_COLLECT: begin
            if (in_valid) begin
               sig_nx = sig_step;
               cnt_nx = cnt_q + CNT_W'(1);
`ifdef MISR_TIMEOUT_EN
               wd_nx  = '0;
`endif
               if (cnt_q == CNT_LAST) begin
                  state_nx = S_DONE;
                  pass_nx  = (sig_step == GOLDEN_SIG);
               end
            end
`ifdef MISR_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               state_nx = S_DONE;
               tmo_nx   = 1'b1;
               pass_nx  = 1'b0;
            end else begin
               wd_nx = wd_q + WD_W'(1);
            end
`endif
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MISR_TIMEOUT_EN
         wd_q    <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_nx;
         sig_q   <= sig_nx;
         cnt_q   <= cnt_nx;
         pass_q  <= pass_nx;
         busy_q  <= (state_nx == S_COLLECT);
         done_q  <= (state_nx == S_DONE);
`ifdef MISR_TIMEOUT_EN
         wd_q    <= wd_nx;
         tmo_q   <= tmo_nx;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign signature  = sig_q;
   assign sample_cnt = cnt_q;
`ifdef MISR_TIMEOUT_EN
   assign timeout    = tmo_q;
`else
   assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_misr.sv
// Directed bench for adder_result_misr: two small instances (2-sample and
// 1-sample runs); timeout behaviour follows MISR_TIMEOUT_EN.
module tb_adder_result_misr;

   logic       clk = 1'b0;
   logic       reset, start, in_valid, cout;
   logic [7:0] data;
   logic       busy, done, pass, timeout;
   logic [7:0] sig;
   logic [1:0] cnt;

   logic       start1, in_valid1, cout1;
   logic [7:0] data1;
   logic       busy1, done1, pass1, timeout1;
   logic [7:0] sig1;
   logic [0:0] cnt1;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   adder_result_misr #(
      .DATA_WIDTH(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'hFF),
      .SAMPLE_COUNT(2), .GOLDEN_SIG(8'hDB), .TIMEOUT_CYCLES(4)
   ) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .data(data), .cout(cout), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .signature(sig), .sample_cnt(cnt)
   );

   adder_result_misr #(
      .DATA_WIDTH(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'hFF),
      .SAMPLE_COUNT(1), .GOLDEN_SIG(8'h00), .TIMEOUT_CYCLES(4096)
   ) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1),
      .data(data1), .cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
      .timeout(timeout1), .signature(sig1), .sample_cnt(cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      vectors++; if (sig !== 8'hFF) begin errors++; $display("FAIL reset_sig: got %h expected ff", sig); end
      vectors++; if (cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
      vectors++; if ({busy, done, pass, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, timeout}); end
      vectors++; if ({busy1, done1, pass1, timeout1, sig1} !== {4'b0000, 8'hFF}) begin errors++; $display("FAIL reset_dut1: got %b/%h expected 0000/ff", {busy1, done1, pass1, timeout1}, sig1); end
   endtask

   task automatic test_basic();
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++; if ({busy, done, sig} !== {2'b10, 8'hFF}) begin errors++; $display("FAIL basic_start: got busy=%b done=%b sig=%h expected 1/0/ff", busy, done, sig); end
      in_valid = 1'b1; data = 8'h00; cout = 1'b0;
      tick();
      vectors++; if (sig !== 8'hE3 || cnt !== 2'd1) begin errors++; $display("FAIL basic_first: got sig=%h cnt=%0d expected e3/1", sig, cnt); end
      vectors++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL basic_first_flags: got busy=%b done=%b expected 1/0", busy, done); end
      tick();
      in_valid = 1'b0;
      vectors++; if (sig !== 8'hDB || cnt !== 2'd2) begin errors++; $display("FAIL basic_final: got sig=%h cnt=%0d expected db/2", sig, cnt); end
      vectors++; if ({busy, done, pass, timeout} !== 4'b0110) begin errors++; $display("FAIL basic_flags: got %b expected 0110", {busy, done, pass, timeout}); end
   endtask

   task automatic test_carry_cancel();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      in_valid1 = 1'b1; data1 = 8'h01; cout1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      vectors++; if (sig1 !== 8'hE3 || cnt1 !== 1'b1) begin errors++; $display("FAIL carry_sig: got sig=%h cnt=%0d expected e3/1", sig1, cnt1); end
      vectors++; if ({busy1, done1, pass1} !== 3'b010) begin errors++; $display("FAIL carry_flags: got %b expected 010", {busy1, done1, pass1}); end
   endtask

   task automatic test_gaps();
      // stray sample while DONE
      in_valid = 1'b1; data = 8'hAA;
      tick();
      in_valid = 1'b0; data = 8'h00;
      vectors++; if ({done, sig, cnt} !== {1'b1, 8'hDB, 2'd2}) begin errors++; $display("FAIL done_hold: got done=%b sig=%h cnt=%0d expected 1/db/2", done, sig, cnt); end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++; if ({busy, sig, cnt} !== {1'b1, 8'hE3, 2'd1}) begin errors++; $display("FAIL stray_start: got busy=%b sig=%h cnt=%0d expected 1/e3/1", busy, sig, cnt); end
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++; if ({done, pass, sig, cnt} !== {2'b11, 8'hDB, 2'd2}) begin errors++; $display("FAIL gaps_final: got done=%b pass=%b sig=%h cnt=%0d expected 1/1/db/2", done, pass, sig, cnt); end
   endtask

   task automatic test_reset_midrun();
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if ({busy, done, pass, timeout, sig, cnt} !== {4'b0000, 8'hFF, 2'd0}) begin errors++; $display("FAIL midrun_reset: got flags=%b sig=%h cnt=%0d expected 0000/ff/0", {busy, done, pass, timeout}, sig, cnt); end
      in_valid = 1'b1; data = 8'h55;
      tick();
      in_valid = 1'b0; data = 8'h00;
      vectors++; if ({busy, sig, cnt} !== {1'b0, 8'hFF, 2'd0}) begin errors++; $display("FAIL idle_stray: got busy=%b sig=%h cnt=%0d expected 0/ff/0", busy, sig, cnt); end
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      vectors++; if ({done, pass, sig} !== {2'b11, 8'hDB}) begin errors++; $display("FAIL rerun: got done=%b pass=%b sig=%h expected 1/1/db", done, pass, sig); end
   endtask

   task automatic test_restart_same_cycle();
      start = 1'b1; in_valid = 1'b1; data = 8'h00;
      tick();
      start = 1'b0; in_valid = 1'b0;
      vectors++; if ({busy, done, pass, sig, cnt} !== {3'b100, 8'hFF, 2'd0}) begin errors++; $display("FAIL restart: got busy=%b done=%b pass=%b sig=%h cnt=%0d expected 1/0/0/ff/0", busy, done, pass, sig, cnt); end
   endtask

   task automatic test_timeout();
      // DUT is in COLLECT with zero samples after test_restart_same_cycle
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      vectors++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL tmo_early: got busy=%b done=%b expected 1/0", busy, done); end
      tick();
`ifdef MISR_TIMEOUT_EN
      vectors++; if ({busy, done, timeout, pass} !== 4'b0110) begin errors++; $display("FAIL tmo_flags: got %b expected 0110", {busy, done, timeout, pass}); end
      vectors++; if (sig !== 8'hE3 || cnt !== 2'd1) begin errors++; $display("FAIL tmo_partial: got sig=%h cnt=%0d expected e3/1", sig, cnt); end
`else
      for (int i = 0; i < 20; i++) tick();
      vectors++; if ({busy, done, timeout} !== 3'b100) begin errors++; $display("FAIL no_watchdog: got %b expected 100", {busy, done, timeout}); end
      vectors++; if (sig !== 8'hE3 || cnt !== 2'd1) begin errors++; $display("FAIL no_watchdog_state: got sig=%h cnt=%0d expected e3/1", sig, cnt); end
`endif
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; data = 8'h00; cout = 1'b0;
      start1 = 1'b0; in_valid1 = 1'b0; data1 = 8'h00; cout1 = 1'b0;
      #2;
      test_reset();
      test_basic();
      test_carry_cancel();
      test_gaps();
      test_reset_midrun();
      test_restart_same_cycle();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/adder_result_misr.md
# adder_result_misr

Response compactor at the output end of the pipelined-adder hardware-evaluation harness. LFSRs drive stimulus into the adder; this block consumes the adder's sum/carry stream qualified by its output valid and compresses it into a multiple-input signature register (MISR). After a programmed number of samples it compares the signature against a golden constant and raises done/pass. A board-level test then needs only a few output pins instead of the full 500-bit result bus.

## Interface
Parameters:
- DATA_WIDTH, 500, width of adder sum input
- SIG_WIDTH, 32, signature width
- POLY, 32'h04C11DB7, MISR feedback polynomial (bit i set = tap on bit i)
- SEED, all ones, signature value loaded on start
- SAMPLE_COUNT, 1024, accepted samples per run (>= 1)
- GOLDEN_SIG, 0, expected final signature
- TIMEOUT_CYCLES, 4096, idle-cycle limit (used only with MISR_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run (pulse)
- in_valid  in  1  sample qualifier (adder out_valid)
- data  in  DATA_WIDTH  adder sum
- cout  in  1  adder carry out
- busy  out  1  high in COLLECT
- done  out  1  high in DONE
- pass  out  1  final signature == GOLDEN_SIG and no timeout
- timeout  out  1  run ended by watchdog
- signature  out  SIG_WIDTH  current MISR value
- sample_cnt  out  $clog2(SAMPLE_COUNT+1)  samples accepted this run

## Operation
- Fold: the vector {cout, data} (DATA_WIDTH+1 bits, data in the LSBs) is zero-padded to a multiple of SIG_WIDTH. The chunks are XORed together into `folded`.
- MISR step: sig_next = (sig << 1, truncated) ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ folded.
- FSM states IDLE, COLLECT, DONE:
  - IDLE: start -> COLLECT; sig <= SEED, cnt <= 0, pass/timeout <= 0. in_valid ignored.
  - COLLECT: each in_valid applies one MISR step and cnt++. If in_valid arrives with cnt == SAMPLE_COUNT-1, go to DONE and set pass <= (sig_next == GOLDEN_SIG). start is ignored.
  - DONE: outputs hold. in_valid is ignored. start re-initialises exactly as from IDLE and enters COLLECT.
- reset, from any state and mid-run: state IDLE, signature = SEED, sample_cnt = 0, busy = done = pass = timeout = 0.
- start and in_valid in the same cycle while in IDLE/DONE: only start acts. That sample is not counted.

## Timing
- All outputs are registered.
- signature and sample_cnt reflect an accepted sample one cycle after the in_valid edge.
- busy rises the cycle after start.
- done, pass and the final signature appear the cycle after the last accepted sample, with busy falling in that same cycle.
- There is no backpressure. One sample per cycle is sustained. Gaps in in_valid are allowed.
- Minimum run: SAMPLE_COUNT+1 cycles from start to done.

## Configuration
- MISR_TIMEOUT_EN defined:
  - A watchdog counter clears on start and on every accepted sample, and increments each COLLECT cycle without in_valid.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with timeout = 1 and pass = 0. signature and sample_cnt keep their partial values.
- Macro undefined: there is no watchdog. timeout is tied 0, and COLLECT waits indefinitely.

## Test plan
Small configuration for all scenarios: DATA_WIDTH=8, SIG_WIDTH=8, POLY=8'h1D, SEED=8'hFF.
- SAMPLE_COUNT=2, GOLDEN_SIG=8'hDB. Stimulus: start, then two samples data=8'h00, cout=0. -> signature E3 after the first sample, DB after the second; done=1, pass=1, sample_cnt=2.
- SAMPLE_COUNT=1. Stimulus: one sample data=8'h01, cout=1 (the carry chunk cancels data bit 0). -> signature E3. With GOLDEN_SIG=8'h00: pass=0, done=1.
- Samples with in_valid gaps, start pulsed mid-COLLECT, and in_valid asserted in IDLE/DONE. -> Signature and count are identical to the gap-free run; stray start and stray in_valid have no effect.
- reset asserted after one of two samples. -> The next cycle shows IDLE, signature FF, sample_cnt 0, all flags 0. A fresh start then reproduces DB.
- From DONE, a start with in_valid in the same cycle. -> Re-seeds to FF, that sample is not counted, and busy=1 on the next cycle.
- MISR_TIMEOUT_EN, TIMEOUT_CYCLES=4. Stimulus: start, one sample, then idle. -> done=1 and timeout=1 four idle cycles later; pass=0, sample_cnt=1. Without the macro, busy stays 1.
